// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped instruction cache with a blocking multi-beat line refill
module instr_cache #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 32 - 2 - WB - IB;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TW-1:0]         tag_q  [NUM_LINES];
    logic [31:0]           data_q [NUM_LINES*WORDS_PER_LINE];
    logic [WB-1:0]         beat_q;
    logic                  pend_q;
    logic [31:0]           base_q;
    logic [15:0]           hit_q, miss_q;

    logic [WB-1:0] lk_word;
    logic [IB-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic [IB-1:0] rf_idx;
    logic          hit;
    logic          last_beat;

    assign lk_word    = cpu_addr[2 +: WB];
    assign lk_idx     = cpu_addr[2+WB +: IB];
    assign lk_tag     = cpu_addr[31 -: TW];
    assign rf_idx     = base_q[2+WB +: IB];
    assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign last_beat  = (beat_q == WB'(WORDS_PER_LINE - 1));
    assign cpu_rdata  = data_q[{lk_idx, lk_word}];
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    always_comb begin
        state_d   = state_q;
        cpu_stall = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = 32'h0;
        case (state_q)
            IDLE: begin
                if (cpu_req && !hit) begin
                    cpu_stall = 1'b1;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = base_q + {{(30-WB){1'b0}}, beat_q, 2'b00};
                if (mem_valid && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
            base_q  <= 32'h0;
            hit_q   <= 16'h0;
            miss_q  <= 16'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        if (hit) begin
                            hit_q <= hit_q + 16'd1;
                        end else begin
                            miss_q <= miss_q + 16'd1;
                            base_q <= {cpu_addr[31:2+WB], {(2+WB){1'b0}}};
                            beat_q <= '0;
                        end
                    end
                    if (inv) begin
                        valid_q <= '0;
                    end
                end
                REFILL: begin
                    if (inv) begin
                        valid_q <= '0;
                        pend_q  <= 1'b1;
                    end
                    if (mem_valid) begin
                        beat_q <= beat_q + WB'(1);
                        // A line refilled across an invalidate must not become visible.
                        if (last_beat) begin
                            valid_q[rf_idx] <= !(pend_q || inv);
                            pend_q          <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == REFILL && mem_valid) begin
            data_q[{rf_idx, beat_q}] <= mem_rdata;
            if (last_beat) begin
                tag_q[rf_idx] <= base_q[31 -: TW];
            end
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - scoreboard bench for instr_cache
module tb_instr_cache;
    logic        clk;
    logic        rst;
    logic        rst_init;
    logic        rst_pulse;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;
    int rcyc     = 0;
    int inv_at   = 0;
    int rst_at   = 0;

    logic [31:0] sb_q[$];
    logic [31:0] exp_beats[$];
    bit          vpat[$];

    instr_cache #(.NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .inv(inv),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .hit_count(hit_count), .miss_count(miss_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
        return a ^ 32'hDEAD0000;
    endfunction

    assign rst       = rst_init | rst_pulse;
    assign mem_rdata = mem_word(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory responder: wait-state pattern plus one-shot inv/rst injection by refill cycle
    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) rcyc++;
        else rcyc = 0;
        inv       = 1'b0;
        rst_pulse = 1'b0;
        if (rcyc != 0 && rcyc == inv_at) begin
            inv    = 1'b1;
            inv_at = 0;
        end
        if (rcyc != 0 && rcyc == rst_at) begin
            rst_pulse = 1'b1;
            rst_at    = 0;
        end
        if (mem_req === 1'b1 && !rst_pulse) mem_valid = (vpat.size() != 0) ? vpat.pop_front() : 1'b1;
        else mem_valid = 1'b0;
    end

    always @(negedge clk) begin
        if (mem_req === 1'b1 && mem_valid && !rst) begin
            if (exp_beats.size() == 0) check("beat_extra", mem_addr, 32'hFFFFFFFF);
            else check("mem_addr", mem_addr, exp_beats.pop_front());
        end
    end

    task automatic access(input logic [31:0] a, input int refills, input int exp_stall);
        int stalls = 0;
        logic [31:0] base;
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_addr = a;
        sb_q.push_back(mem_word({a[31:2], 2'b00}));
        base = {a[31:4], 4'h0};
        for (int r = 0; r < refills; r++)
            for (int w = 0; w < 4; w++) exp_beats.push_back(base + 32'(4*w));
        forever begin
            @(negedge clk);
            if (!cpu_stall) begin
                check("rdata", cpu_rdata, sb_q.pop_front());
                break;
            end
            stalls++;
            if (stalls > 40) begin
                check("stall_timeout", 32'(stalls), 32'(exp_stall));
                void'(sb_q.pop_front());
                break;
            end
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] h0, m0;
        int guard;
        rst_init = 1'b1; rst_pulse = 1'b0; inv = 1'b0; mem_valid = 1'b0;
        cpu_req = 1'b0; cpu_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_init = 1'b0;
        @(negedge clk);
        check("rst_hit_count", 32'(hit_count), 32'h0);
        check("rst_miss_count", 32'(miss_count), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_stall_noreq", 32'(cpu_stall), 32'h0);

        // Cold miss then same-line hits
        access(32'h100, 1, 5);
        idle_step();
        check("cold_miss_count", 32'(miss_count), 32'd1);
        h0 = hit_count;
        access(32'h104, 0, 0);
        access(32'h108, 0, 0);
        access(32'h10C, 0, 0);
        idle_step();
        check("hits_delta", 32'(hit_count - h0), 32'd3);

        // Conflicting tags on line 0
        m0 = miss_count;
        access(32'h200, 1, 5);
        access(32'h100, 1, 5);
        access(32'h200, 1, 5);
        idle_step();
        check("conflict_miss_delta", 32'(miss_count - m0), 32'd3);

        // Wait states during refill
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        access(32'h300, 1, 8);
        access(32'h30C, 0, 0);
        idle_step();

        // Invalidate mid-refill: refilled line stays invalid, other lines lost
        access(32'h140, 1, 5);
        m0 = miss_count;
        inv_at = 2;
        access(32'h100, 2, 10);
        idle_step();
        check("inv_miss_delta", 32'(miss_count - m0), 32'd2);
        access(32'h140, 1, 5);
        idle_step();

        // Reset mid-refill
        rst_at = 3;
        exp_beats.push_back(32'h200);
        exp_beats.push_back(32'h204);
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h200;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (rst !== 1'b1 && guard < 20);
        check("rst_pulse_seen", 32'(rst), 32'h1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("abort_mem_req", 32'(mem_req), 32'h0);
        check("abort_hit_count", 32'(hit_count), 32'h0);
        check("abort_miss_count", 32'(miss_count), 32'h0);
        access(32'h100, 1, 5);
        idle_step();
        check("post_abort_miss", 32'(miss_count), 32'd1);
        check("beats_left", 32'(exp_beats.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16: number of direct-mapped lines, power of two.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4: 32-bit words per line, power of two.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- cpu_req  input  1  IF stage fetch request.
- cpu_addr  input  32  fetch byte address; bits [1:0] ignored.
- cpu_rdata  output  32  instruction word; valid when cpu_req=1 and cpu_stall=0.
- cpu_stall  output  1  freeze PC and IF/ID.
- inv  input  1  invalidate all lines.
- mem_req  output  1  refill beat request to backing instruction memory.
- mem_addr  output  32  word address of the requested beat, word-aligned.
- mem_rdata  input  32  beat data.
- mem_valid  input  1  mem_rdata valid this cycle; beat accepted.
- hit_count  output  16  hit counter.
- miss_count  output  16  miss counter.

Function
REQ-004 SHALL decompose cpu_addr as offset [1:0], word index log2(WORDS_PER_LINE) bits, line index log2(NUM_LINES) bits, and tag = remaining upper bits.
REQ-005 SHALL hold per line: valid bit, tag, WORDS_PER_LINE data words.
REQ-006 SHALL implement FSM states IDLE and REFILL; reset state IDLE.
REQ-007 IDLE, cpu_req=1, valid and tag match (hit): cpu_rdata = stored word combinationally, cpu_stall=0, hit_count+1.
REQ-008 IDLE, cpu_req=1, miss: cpu_stall=1 combinationally that cycle; latch line base address (offset and word bits zeroed); clear beat counter to 0; go to REFILL; miss_count+1.
REQ-009 IDLE, cpu_req=0: cpu_stall=0, mem_req=0, no counter change.
REQ-010 REFILL: mem_req=1, mem_addr = latched base + 4 * beat counter, cpu_stall=1 regardless of cpu_req and cpu_addr.
REQ-011 REFILL with mem_valid=1: write mem_rdata to word[beat counter] of the target line; increment counter. With mem_valid=0: hold all state (arbitrary wait states).
REQ-012 On acceptance of the last beat: write tag, set valid (subject to REQ-014), return to IDLE. The lookup in the following IDLE cycle uses the then-current cpu_addr.
REQ-013 Zero-wait-state miss latency: cpu_stall high for exactly 1 + WORDS_PER_LINE cycles; hit in the next cycle.
REQ-014 inv in IDLE: clear all valid bits at the next edge; the lookup in that same cycle still behaves per REQ-007/008. inv during REFILL: clear all valid bits, set pending flag; the in-flight refill completes but leaves its line invalid; flag clears on return to IDLE.
REQ-015 cpu_req or cpu_addr changes during REFILL SHALL NOT alter the latched refill address.
REQ-016 hit_count and miss_count SHALL wrap modulo 2^16.
REQ-017 The refill write to a line and a lookup of that line SHALL never coincide, because lookups occur only in IDLE.

Reset
REQ-018 rst SHALL set: state IDLE, all valid bits 0, beat counter 0, pending flag 0, hit_count 0, miss_count 0, mem_req 0, mem_addr 0.
REQ-019 In the cycle after reset, cpu_stall SHALL equal cpu_req, because every lookup misses.
REQ-020 rst asserted during REFILL SHALL abort the refill: IDLE next cycle, mem_req=0, partially refilled line invalid.
REQ-021 Data and tag arrays need not be reset.

Verification
REQ-022 Cold miss: reset; cpu_req=1, cpu_addr=0x100; memory returns 0xA0..0xA3, zero wait. Required: mem_addr 0x100, 0x104, 0x108, 0x10C; stall for 5 cycles; then cpu_rdata=0xA0 with stall=0; miss_count=1.
REQ-023 Same-line hits: following REQ-022, addresses 0x104, 0x108, 0x10C on consecutive cycles. Required: rdata 0xA1, 0xA2, 0xA3 with no stall; hit_count=3.
REQ-024 Conflict: addresses 0x100 and 0x200 (same index, NUM_LINES=16) alternate. Required: each access misses and refills; miss_count increments every access.
REQ-025 Wait states: mem_valid pattern 1,0,0,1,1,0,1 during a refill. Required: exactly 4 beats written; stall spans 8 cycles; the returned word is correct.
REQ-026 inv mid-refill: inv pulsed on the 2nd REFILL cycle of 0x100. Required: refill completes; the next access to 0x100 misses again; previously valid lines also miss.
REQ-027 Reset mid-refill: rst on the 3rd REFILL cycle. Required: mem_req=0 next cycle; both counters 0; 0x100 misses and fully refills.
